// File: rtl/washer_plant_sensor_model.sv
// rtl/washer_plant_sensor_model.sv - washer plant stand-in: tank level, detergent dispenser, wash/spin timers
// Consumes actuator commands and returns the sensor/timeout strobes the wash controller waits on.
module washer_plant_sensor_model #(
  parameter int LEVEL_W     = 8,
  parameter int FULL_LEVEL  = 200,
  parameter int FILL_RATE   = 4,
  parameter int DRAIN_RATE  = 5,
  parameter int TIMER_W     = 16,
  parameter int CYCLE_TICKS = 1000,
  parameter int SPIN_TICKS  = 500,
  parameter int DET_DELAY   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               door_lock_i,
  input  logic               motor_on_i,
  input  logic               fill_value_on_i,
  input  logic               drain_value_on_i,
  input  logic               soap_wash_i,
  output logic               filled_o,
  output logic               detergent_added_o,
  output logic               cycle_timeout_o,
  output logic               drained_o,
  output logic               spin_timeout_o,
  output logic [LEVEL_W-1:0] water_level_o,
  output logic               fault_o
);

  localparam logic [LEVEL_W:0]   FULL_X   = (LEVEL_W+1)'(FULL_LEVEL);
  localparam logic [LEVEL_W:0]   FILL_X   = (LEVEL_W+1)'(FILL_RATE);
  localparam logic [LEVEL_W:0]   DRAIN_X  = (LEVEL_W+1)'(DRAIN_RATE);
  localparam logic [LEVEL_W-1:0] FULL_L   = LEVEL_W'(FULL_LEVEL);
  localparam logic [TIMER_W-1:0] CYC_T    = TIMER_W'(CYCLE_TICKS);
  localparam logic [TIMER_W-1:0] SPIN_T   = TIMER_W'(SPIN_TICKS);
  localparam logic [TIMER_W-1:0] DET_LAST = TIMER_W'(DET_DELAY - 1);
  localparam logic [TIMER_W-1:0] ONE_T    = TIMER_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    DONE
  } disp_state_e;

  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W:0]   lvl_ext, lvl_sum, lvl_dif;
  logic [TIMER_W-1:0] cyc_q, cyc_d;
  logic [TIMER_W-1:0] spin_q, spin_d;
  logic [TIMER_W-1:0] det_cnt_q, det_cnt_nxt;
  logic               fault_q, fault_d;
  logic               soap_q;
  logic               det_q;
  disp_state_e        state_q;

  // Level arithmetic is one bit wider than the register so saturation never sees a wrap.
  always_comb begin
    lvl_ext = {1'b0, level_q};
    lvl_sum = lvl_ext + FILL_X;
    lvl_dif = lvl_ext - DRAIN_X;
    level_d = level_q;
    if (fill_value_on_i && !drain_value_on_i && door_lock_i) begin
      level_d = (lvl_sum > FULL_X) ? FULL_L : lvl_sum[LEVEL_W-1:0];
    end else if (drain_value_on_i && !fill_value_on_i) begin
      level_d = (lvl_ext < DRAIN_X) ? '0 : lvl_dif[LEVEL_W-1:0];
    end
  end

  always_comb begin
    fault_d = fault_q
            | (fill_value_on_i && drain_value_on_i)
            | (motor_on_i && !door_lock_i)
            | (fill_value_on_i && !door_lock_i);

    cyc_d = cyc_q;
    if (!motor_on_i) begin
      cyc_d = '0;
    end else if (door_lock_i && cyc_q != CYC_T) begin
      cyc_d = cyc_q + ONE_T;
    end

    // Spin only advances on an empty tank with the door shut and the motor idle.
    spin_d = spin_q;
    if (!drain_value_on_i) begin
      spin_d = '0;
    end else if (drained_o && door_lock_i && !motor_on_i && spin_q != SPIN_T) begin
      spin_d = spin_q + ONE_T;
    end

    det_cnt_nxt = det_cnt_q + ONE_T;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
      cyc_q   <= '0;
      spin_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cyc_q   <= cyc_d;
      spin_q  <= spin_d;
      fault_q <= fault_d;
    end
  end

  // Dispenser: one dispense per soap phase, done strobe held until the phase ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      det_cnt_q <= '0;
      det_q     <= 1'b0;
      soap_q    <= 1'b0;
    end else begin
      soap_q <= soap_wash_i;
      case (state_q)
        IDLE: begin
          if (soap_wash_i && !soap_q) begin
            state_q   <= DISPENSE;
            det_cnt_q <= '0;
          end
        end
        DISPENSE: begin
          if (!soap_wash_i) begin
            state_q <= IDLE;
          end else begin
            det_cnt_q <= det_cnt_nxt;
            if (det_cnt_nxt == DET_LAST) begin
              state_q <= DONE;
              det_q   <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!soap_wash_i) begin
            state_q <= IDLE;
            det_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          det_q   <= 1'b0;
        end
      endcase
    end
  end

  assign water_level_o     = level_q;
  assign filled_o          = (level_q == FULL_L);
  assign drained_o         = (level_q == '0);
  assign cycle_timeout_o   = (cyc_q == CYC_T);
  assign spin_timeout_o    = (spin_q == SPIN_T);
  assign detergent_added_o = det_q;
  assign fault_o           = fault_q;

endmodule

// File: tb/tb_washer_plant_sensor_model.sv
// tb/tb_washer_plant_sensor_model.sv - directed scoreboard bench for washer_plant_sensor_model
module tb_washer_plant_sensor_model;

  localparam int S_LEVEL = 0;
  localparam int S_FILL  = 1;
  localparam int S_DRN   = 2;
  localparam int S_DET   = 3;
  localparam int S_CTO   = 4;
  localparam int S_STO   = 5;
  localparam int S_FLT   = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       door_lock = 1'b0, motor_on = 1'b0, fill_on = 1'b0, drain_on = 1'b0, soap_wash = 1'b0;
  logic       filled, detergent_added, cycle_timeout, drained, spin_timeout, fault;
  logic [7:0] water_level;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  washer_plant_sensor_model dut (
    .clk               (clk),
    .reset             (reset),
    .door_lock_i       (door_lock),
    .motor_on_i        (motor_on),
    .fill_value_on_i   (fill_on),
    .drain_value_on_i  (drain_on),
    .soap_wash_i       (soap_wash),
    .filled_o          (filled),
    .detergent_added_o (detergent_added),
    .cycle_timeout_o   (cycle_timeout),
    .drained_o         (drained),
    .spin_timeout_o    (spin_timeout),
    .water_level_o     (water_level),
    .fault_o           (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_LEVEL: return 32'(water_level);
      S_FILL:  return 32'(filled);
      S_DRN:   return 32'(drained);
      S_DET:   return 32'(detergent_added);
      S_CTO:   return 32'(cycle_timeout);
      S_STO:   return 32'(spin_timeout);
      default: return 32'(fault);
    endcase
  endfunction

  function automatic void expect_v(string tag, int sel, int exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = 32'(exp);
    sb.push_back(e);
  endfunction

  task automatic check_sb();
    sb_t         e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_cmp++;
      assert (obs === e.exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_reset_state(string pfx);
    expect_v({pfx, "_level"}, S_LEVEL, 0);
    expect_v({pfx, "_drained"}, S_DRN, 1);
    expect_v({pfx, "_filled"}, S_FILL, 0);
    expect_v({pfx, "_det"}, S_DET, 0);
    expect_v({pfx, "_cto"}, S_CTO, 0);
    expect_v({pfx, "_sto"}, S_STO, 0);
    expect_v({pfx, "_fault"}, S_FLT, 0);
    check_sb();
  endtask

  initial begin
    // Reset state
    tick(3);
    expect_reset_state("rst");

    // Fill from empty: +4 per clk, filled exactly when 200 is reached
    reset = 1'b1;
    door_lock = 1'b1;
    fill_on = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      expect_v($sformatf("fill_lvl_%0d", i), S_LEVEL, (4 * i > 200) ? 200 : 4 * i);
      expect_v($sformatf("fill_full_%0d", i), S_FILL, (i == 50) ? 1 : 0);
      check_sb();
    end
    tick(3);
    expect_v("fill_hold_lvl", S_LEVEL, 200);
    expect_v("fill_hold_full", S_FILL, 1);
    expect_v("fill_fault", S_FLT, 0);
    check_sb();

    // Drain from full: -5 per clk, clamp at 0
    fill_on = 1'b0;
    drain_on = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      expect_v($sformatf("drain_lvl_%0d", i), S_LEVEL, 200 - 5 * i);
      expect_v($sformatf("drain_full_%0d", i), S_FILL, 0);
      expect_v($sformatf("drain_empty_%0d", i), S_DRN, (i == 40) ? 1 : 0);
      check_sb();
    end
    tick(2);
    expect_v("drain_clamp_lvl", S_LEVEL, 0);
    expect_v("drain_clamp_empty", S_DRN, 1);
    check_sb();

    // Spin timer on an empty tank
    drain_on = 1'b0;
    tick(1);
    expect_v("spin_clear", S_STO, 0);
    check_sb();
    drain_on = 1'b1;
    tick(499);
    expect_v("spin_499", S_STO, 0);
    check_sb();
    tick(1);
    expect_v("spin_500", S_STO, 1);
    check_sb();
    tick(5);
    expect_v("spin_sat", S_STO, 1);
    check_sb();
    drain_on = 1'b0;
    tick(1);
    expect_v("spin_drop", S_STO, 0);
    check_sb();

    // Detergent dispenser: strobe 16 clks after soap rises, held, no retrigger
    soap_wash = 1'b1;
    tick(15);
    expect_v("det_15", S_DET, 0);
    check_sb();
    tick(1);
    expect_v("det_16", S_DET, 1);
    check_sb();
    tick(20);
    expect_v("det_held", S_DET, 1);
    check_sb();
    soap_wash = 1'b0;
    tick(1);
    expect_v("det_fall", S_DET, 0);
    check_sb();
    tick(20);
    expect_v("det_stay_low", S_DET, 0);
    check_sb();

    // Fill and drain together: level frozen, sticky fault
    fill_on = 1'b1;
    tick(5);
    expect_v("ff_pre_lvl", S_LEVEL, 20);
    expect_v("ff_pre_fault", S_FLT, 0);
    check_sb();
    drain_on = 1'b1;
    tick(5);
    expect_v("ff_lvl", S_LEVEL, 20);
    expect_v("ff_fault", S_FLT, 1);
    check_sb();
    fill_on = 1'b0;
    drain_on = 1'b0;
    tick(3);
    expect_v("ff_sticky", S_FLT, 1);
    check_sb();

    // Reset asserted mid-fill at level 120, checked before any clock edge
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    fill_on = 1'b1;
    tick(30);
    expect_v("mid_lvl", S_LEVEL, 120);
    check_sb();
    #3;
    reset = 1'b0;
    #2;
    expect_reset_state("async");
    fill_on = 1'b0;
    tick(2);
    reset = 1'b1;

    // Cycle timer: timeout on the 1000th motor clk, cleared by a single idle clk
    motor_on = 1'b1;
    tick(999);
    expect_v("cyc_999", S_CTO, 0);
    check_sb();
    tick(1);
    expect_v("cyc_1000", S_CTO, 1);
    check_sb();
    tick(3);
    expect_v("cyc_sat", S_CTO, 1);
    check_sb();
    motor_on = 1'b0;
    tick(1);
    expect_v("cyc_clear", S_CTO, 0);
    check_sb();
    motor_on = 1'b1;
    tick(400);
    motor_on = 1'b0;
    tick(1);
    motor_on = 1'b1;
    tick(999);
    expect_v("cyc_restart_999", S_CTO, 0);
    check_sb();
    tick(1);
    expect_v("cyc_restart_1000", S_CTO, 1);
    check_sb();

    // Door drop pauses the timer and flags the illegal motor command
    motor_on = 1'b0;
    tick(1);
    motor_on = 1'b1;
    tick(500);
    expect_v("pause_pre_fault", S_FLT, 0);
    check_sb();
    door_lock = 1'b0;
    tick(10);
    expect_v("pause_cto", S_CTO, 0);
    expect_v("pause_fault", S_FLT, 1);
    check_sb();
    door_lock = 1'b1;
    tick(499);
    expect_v("pause_999", S_CTO, 0);
    check_sb();
    tick(1);
    expect_v("pause_1000", S_CTO, 1);
    check_sb();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
